// File: rtl/program_loader_if.sv
// Loader-side bundle: program byte stream in, instruction-memory writes and
// processor-control status out. The loader itself uses the slave modport.
interface program_loader_if;
    logic        start;
    logic [15:0] len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        output start, len_words, byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata, cpu_reset, done, error
    );

    modport slave (
        input  start, len_words, byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Streams a byte-serial program into instruction memory and holds the processor in reset
// until the load completes. Define PROGRAM_LOADER_CHECKSUM_EN to add a trailing checksum check.
module program_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        StCheck = 3'd2,
`endif
        StRun   = 3'd3,
        StErr   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] buf_q, buf_d;
    logic        im_we_q, im_we_d;
    logic [31:0] im_addr_q, im_addr_d;
    logic [31:0] im_wdata_q, im_wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;
`endif

    logic        byte_ready;
    logic        accept;
    logic        len_valid;
    logic [31:0] word;

    always_comb begin
        byte_ready = (state_q == StLoad);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        byte_ready = byte_ready || (state_q == StCheck);
`endif
    end

    assign accept    = bus.byte_valid && byte_ready;
    assign len_valid = (bus.len_words != 16'd0) && (32'(bus.len_words) <= MAX_WORDS);
    // Earlier bytes of the word sit in buf_q; the current byte completes it.
    assign word      = {buf_q, bus.byte_data};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        unique case (state_q)
            StIdle, StRun, StErr: begin
                if (bus.start) begin
                    if (len_valid) begin
                        state_d    = StLoad;
                        len_d      = bus.len_words;
                        word_cnt_d = 16'd0;
                        byte_cnt_d = 2'd0;
                        buf_d      = 24'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum_d = 32'd0;
`endif
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = {buf_q[15:0], bus.byte_data};
                    if (byte_cnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = word;
                        im_addr_d  = ADDR_BASE + {14'd0, word_cnt_q, 2'b00};
                        word_cnt_d = word_cnt_q + 16'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum_d = checksum_q + word;
                        if (word_cnt_q == len_q - 16'd1) state_d = StCheck;
`else
                        if (word_cnt_q == len_q - 16'd1) state_d = StRun;
`endif
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = {buf_q[15:0], bus.byte_data};
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (word == checksum_q) ? StRun : StErr;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= 16'd0;
            word_cnt_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            buf_q      <= 24'd0;
            im_we_q    <= 1'b0;
            im_addr_q  <= 32'd0;
            im_wdata_q <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum_q <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    // The final word's strobe lands in the first RUN cycle; no write is ever issued from RUN.
    assign bus.byte_ready = byte_ready;
    assign bus.im_we      = im_we_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.im_wdata   = im_wdata_q;
    assign bus.cpu_reset  = (state_q != StRun);
    assign bus.done       = (state_q == StRun);
    assign bus.error      = (state_q == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: expected memory writes are queued as bytes are
// driven and matched against im_we pulses; checksum cases follow PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [31:0] cs_sum;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader #(
        .ADDR_BASE(32'h0000_0000),
        .MAX_WORDS(256)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_we", 64'(bus.im_we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("we_addr", 64'(bus.im_addr), 64'(mon_e.addr));
                check_eq("we_data", 64'(bus.im_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic check_state(input string t, input logic rdy, input logic crst,
                               input logic dn, input logic err);
        check_eq({t, "_ready"}, 64'(bus.byte_ready), 64'(rdy));
        check_eq({t, "_cpu_reset"}, 64'(bus.cpu_reset), 64'(crst));
        check_eq({t, "_done"}, 64'(bus.done), 64'(dn));
        check_eq({t, "_error"}, 64'(bus.error), 64'(err));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (bus.byte_ready !== 1'b1) check_eq("ready_wait", 64'(bus.byte_ready), 64'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_w32(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] w, input bit gap);
        exp_q.push_back('{addr: addr, data: w});
        cs_sum = cs_sum + w;
        send_w32(w, gap);
    endtask

    task automatic do_start(input logic [15:0] len);
        bus.start     = 1'b1;
        bus.len_words = len;
        cs_sum        = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic finish_run(input string t);
        #1;
        check_eq({t, "_pending"}, 64'(exp_q.size()), 64'd0);
        check_state(t, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.len_words  = 16'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        cs_sum         = 32'd0;
        repeat (2) @(negedge clk);
        check_state("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("rst_we", 64'(bus.im_we), 64'd0);
        check_eq("rst_addr", 64'(bus.im_addr), 64'd0);
        check_eq("rst_wdata", 64'(bus.im_wdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word back-to-back load
        do_start(16'd2);
        check_state("load", 1'b1, 1'b1, 1'b0, 1'b0);
        load_word(32'h0, 32'h2008_0005, 1'b0);
        load_word(32'h4, 32'h2009_0007, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check_eq("cs_model", 64'(cs_sum), 64'h4011_000C);
        send_w32(cs_sum, 1'b0);
`endif
        finish_run("basic");
        @(negedge clk);
        check_eq("run_we_low", 64'(bus.im_we), 64'd0);

        // Reload from RUN
        do_start(16'd1);
        check_state("reload", 1'b1, 1'b1, 1'b0, 1'b0);
        load_word(32'h0, 32'hAABB_CCDD, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_w32(cs_sum, 1'b0);
`endif
        finish_run("reload");

        // Rejected lengths
        do_start(16'd0);
        check_state("len0", 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("len0_ready_hold", 64'(bus.byte_ready), 64'd0);
        do_start(16'd257);
        check_state("len257", 1'b0, 1'b1, 1'b0, 1'b1);

        // Three words with byte_valid toggling; valid start leaves ERR
        do_start(16'd3);
        check_state("gap_start", 1'b1, 1'b1, 1'b0, 1'b0);
        load_word(32'h0, 32'h2008_0005, 1'b1);
        load_word(32'h4, 32'h2009_0007, 1'b1);
        load_word(32'h8, 32'hAABB_CCDD, 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_w32(cs_sum, 1'b1);
`endif
        finish_run("gap");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum off by one
        do_start(16'd2);
        load_word(32'h0, 32'h2008_0005, 1'b0);
        load_word(32'h4, 32'h2009_0007, 1'b0);
        send_w32(cs_sum + 32'd1, 1'b0);
        #1;
        check_eq("cs_bad_pending", 64'(exp_q.size()), 64'd0);
        check_state("cs_bad", 1'b0, 1'b1, 1'b0, 1'b1);
`endif

        // Reset after 6 of 8 bytes
        do_start(16'd2);
        load_word(32'h0, 32'h2008_0005, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h09, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_state("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("mid_rst_we", 64'(bus.im_we), 64'd0);
        check_eq("mid_rst_addr", 64'(bus.im_addr), 64'd0);
        check_eq("mid_rst_wdata", 64'(bus.im_wdata), 64'd0);
        check_eq("mid_rst_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_state("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
